mbist_march_ctrl: RTL and testbench

March C- built-in self-test controller that sits directly upstream of the `fault_mem` memory model. It generates the `write_read` / `address` / `wdata` stimulus for the memory and checks the registered `rdata` returned two cycles later. It reports pass/fail, the first failing address and a saturating failure count. One run covers every address 0..CAPACITY.

---
 rtl/mbist_march_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_mbist_march_ctrl.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/mbist_march_ctrl.sv
// rtl/mbist_march_ctrl.sv - March C- memory BIST controller with 2-stage read compare.
// Drives write/read/address/wdata to the memory and checks rdata two cycles after each read.
module mbist_march_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int CAPACITY   = 15,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [CNT_WIDTH-1:0]  fail_count,
  output logic                  write_read,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] CAP_A = ADDR_WIDTH'(CAPACITY);
  localparam logic [DATA_WIDTH-1:0] D0    = '0;
  localparam logic [DATA_WIDTH-1:0] D1    = '1;

  state_t                state_q, state_d;
  logic [2:0]            elem_q, elem_d;
  logic                  phase_q, phase_d;
  logic                  drain_q, drain_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  wr_q, wr_d;
  logic                  chk_q, chk_d;
  logic [DATA_WIDTH-1:0] exp_q, exp_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  fail_q, fail_d;
  logic [ADDR_WIDTH-1:0] fail_addr_q, fail_addr_d;
  logic [CNT_WIDTH-1:0]  fail_count_q, fail_count_d;

  logic                  s1_valid_q, s2_valid_q;
  logic [DATA_WIDTH-1:0] s1_exp_q, s2_exp_q;
  logic [ADDR_WIDTH-1:0] s1_addr_q, s2_addr_q;

  logic       last_op;
  logic       last_addr;
  logic [2:0] elem_nx;

  function automatic logic is_desc(input logic [2:0] e);
    return (e == 3'd3) || (e == 3'd4);
  endfunction

  function automatic logic two_op(input logic [2:0] e);
    return (e >= 3'd1) && (e <= 3'd4);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] wr_value(input logic [2:0] e);
    return ((e == 3'd1) || (e == 3'd3)) ? D1 : D0;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] rd_value(input logic [2:0] e);
    return ((e == 3'd2) || (e == 3'd4)) ? D1 : D0;
  endfunction

  assign last_op   = !two_op(elem_q) || phase_q;
  assign last_addr = is_desc(elem_q) ? (addr_q == '0) : (addr_q == CAP_A);
  assign elem_nx   = elem_q + 3'd1;

  always_comb begin
    state_d      = state_q;
    elem_d       = elem_q;
    phase_d      = phase_q;
    drain_d      = drain_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wr_d         = 1'b0;
    chk_d        = 1'b0;
    exp_d        = exp_q;
    busy_d       = busy_q;
    done_d       = done_q;
    fail_d       = fail_q;
    fail_addr_d  = fail_addr_q;
    fail_count_d = fail_count_q;

    if (s2_valid_q && (rdata != s2_exp_q)) begin
      fail_d = 1'b1;
      if (!fail_q) fail_addr_d = s2_addr_q;
      if (fail_count_q != '1) fail_count_d = fail_count_q + 1'b1;
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d      = S_SETUP;
          elem_d       = 3'd0;
          phase_d      = 1'b0;
          addr_d       = '0;
          wdata_d      = wr_value(3'd0);
          busy_d       = 1'b1;
          done_d       = 1'b0;
          fail_d       = 1'b0;
          fail_addr_d  = '0;
          fail_count_d = '0;
        end
      end
      S_SETUP: begin
        // Only E0 opens with a write; every other element opens with a checked read.
        state_d = S_RUN;
        phase_d = 1'b0;
        wr_d    = (elem_q == 3'd0);
        chk_d   = (elem_q != 3'd0);
        exp_d   = rd_value(elem_q);
      end
      S_RUN: begin
        if (!last_op) begin
          phase_d = 1'b1;
          wr_d    = 1'b1;
        end else if (!last_addr) begin
          phase_d = 1'b0;
          addr_d  = is_desc(elem_q) ? addr_q - 1'b1 : addr_q + 1'b1;
          wr_d    = (elem_q == 3'd0);
          chk_d   = (elem_q != 3'd0);
        end else if (elem_q == 3'd5) begin
          state_d = S_DRAIN;
          drain_d = 1'b0;
        end else begin
          state_d = S_SETUP;
          elem_d  = elem_nx;
          phase_d = 1'b0;
          addr_d  = is_desc(elem_nx) ? CAP_A : '0;
          wdata_d = wr_value(elem_nx);
        end
      end
      S_DRAIN: begin
        if (drain_q) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          drain_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      elem_q       <= 3'd0;
      phase_q      <= 1'b0;
      drain_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wr_q         <= 1'b0;
      chk_q        <= 1'b0;
      exp_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
      fail_addr_q  <= '0;
      fail_count_q <= '0;
      s1_valid_q   <= 1'b0;
      s1_exp_q     <= '0;
      s1_addr_q    <= '0;
      s2_valid_q   <= 1'b0;
      s2_exp_q     <= '0;
      s2_addr_q    <= '0;
    end else begin
      state_q      <= state_d;
      elem_q       <= elem_d;
      phase_q      <= phase_d;
      drain_q      <= drain_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wr_q         <= wr_d;
      chk_q        <= chk_d;
      exp_q        <= exp_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      fail_q       <= fail_d;
      fail_addr_q  <= fail_addr_d;
      fail_count_q <= fail_count_d;
      // The read on the bus in cycle k is compared against rdata in cycle k+2.
      s1_valid_q   <= chk_q;
      s1_exp_q     <= exp_q;
      s1_addr_q    <= addr_q;
      s2_valid_q   <= s1_valid_q;
      s2_exp_q     <= s1_exp_q;
      s2_addr_q    <= s1_addr_q;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign fail       = fail_q;
  assign fail_addr  = fail_addr_q;
  assign fail_count = fail_count_q;
  assign write_read = wr_q;
  assign address    = addr_q;
  assign wdata      = wdata_q;

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// tb/tb_mbist_march_ctrl.sv - Bench for mbist_march_ctrl with a faultable memory model.
module tb_mbist_march_ctrl;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int N  = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  always #5 clk = ~clk;

  logic          busy, done, fail, write_read;
  logic [AW-1:0] fail_addr, address;
  logic [7:0]    fail_count;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata = '0;

  logic          busy2, done2, fail2, write_read2;
  logic [AW-1:0] fail_addr2, address2;
  logic [1:0]    fail_count2;
  logic [DW-1:0] wdata2;
  logic [DW-1:0] rdata2 = '0;

  mbist_march_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CAPACITY(15), .CNT_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .fail(fail),
    .fail_addr(fail_addr), .fail_count(fail_count), .write_read(write_read),
    .address(address), .wdata(wdata), .rdata(rdata)
  );

  // Second instance: narrow counter, every cell stuck-at-0 (rdata always zero).
  mbist_march_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CAPACITY(15), .CNT_WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .busy(busy2), .done(done2), .fail(fail2),
    .fail_addr(fail_addr2), .fail_count(fail_count2), .write_read(write_read2),
    .address(address2), .wdata(wdata2), .rdata(rdata2)
  );

  // Memory model: write uses wdata from the previous cycle, rdata is registered twice.
  logic [DW-1:0] mem [0:N-1];
  logic [DW-1:0] wd_q = '0;
  logic [DW-1:0] rd1 = '0;
  int mode = 0;

  initial for (int i = 0; i < N; i++) mem[i] = 8'h5A;

  always @(posedge clk) begin
    wd_q <= wdata;
    if (write_read) begin
      mem[address] <= wd_q;
      if (mode == 2 && address == 4'd9) mem[10] <= wd_q;
    end
    rd1   <= mem[address] | ((mode == 1 && address == 4'd5) ? 8'h01 : 8'h00);
    rdata <= rd1;
  end

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int mode;
    bit poke;
    int exp_fail;
    int exp_addr;
    int exp_cnt;
  } vec_t;

  vec_t vecs[4];

  task automatic run_one(input vec_t v);
    int n, wr, rdc, overlap;
    mode = v.mode;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    n = 0; wr = 0; rdc = 0; overlap = 0;
    while (n < 400) begin
      if (busy && done) overlap++;
      if (write_read) wr++;
      if (busy && !write_read) rdc++;
      if (done) break;
      @(posedge clk); #1;
      n++;
      if (v.poke && n == 20) start = 1'b1;
      if (v.poke && n == 21) start = 1'b0;
    end
    check("done_seen", done, 1);
    check("run_len", n, 168);
    check("writes", wr, 80);
    check("busy_reads", rdc, 88);
    check("busy_done_overlap", overlap, 0);
    check("busy_at_done", busy, 0);
    check("fail", fail, v.exp_fail);
    check("fail_addr", fail_addr, v.exp_addr);
    check("fail_count", fail_count, v.exp_cnt);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_fail"}, fail, 0);
    check({tag, "_fail_addr"}, fail_addr, 0);
    check({tag, "_fail_count"}, fail_count, 0);
    check({tag, "_write_read"}, write_read, 0);
    check({tag, "_address"}, address, 0);
    check({tag, "_wdata"}, wdata, 0);
  endtask

  initial begin
    int wr_after;
    vecs[0] = '{mode: 0, poke: 1'b0, exp_fail: 0, exp_addr: 0,  exp_cnt: 0};
    vecs[1] = '{mode: 1, poke: 1'b0, exp_fail: 1, exp_addr: 5,  exp_cnt: 3};
    vecs[2] = '{mode: 2, poke: 1'b0, exp_fail: 1, exp_addr: 10, exp_cnt: 2};
    vecs[3] = '{mode: 0, poke: 1'b1, exp_fail: 0, exp_addr: 0,  exp_cnt: 0};

    repeat (3) @(posedge clk);
    #1 check_reset_values("rst");
    rst = 1'b0;
    @(posedge clk); #1;
    check_reset_values("idle");

    for (int i = 0; i < 4; i++) run_one(vecs[i]);

    check("sa0_done", done2, 1);
    check("sa0_fail", fail2, 1);
    check("sa0_fail_addr", fail_addr2, 0);
    check("sa0_fail_count", fail_count2, 3);

    // Abort 50 cycles into a run.
    mode = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (50) @(posedge clk);
    #2 rst = 1'b1;
    #1 check_reset_values("abort");
    wr_after = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (write_read) wr_after++;
    end
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (write_read) wr_after++;
    end
    check("abort_no_writes", wr_after, 0);
    check("abort_idle_busy", busy, 0);
    run_one(vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
